// File: rtl/stream_checksum.sv
// stream_checksum
//   Computes the 16-bit ones-complement (Internet) checksum and the
//   qualified byte count of a packet that arrives as a valid/ready stream.
//   One result is presented per packet and held until it is accepted.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   s_valid     input beat present
//   s_ready     block can accept a beat (state ACC)
//   s_data      DATA_W-bit beat; 16-bit word k = s_data[16k+15:16k]
//   s_keep      byte qualifiers; bit j qualifies s_data[8j+7:8j]
//   s_last      final beat of the packet
//   seed        initial partial sum, sampled on the first beat of a packet
//   csum_valid  result presented (state DONE)
//   csum_ready  consumer accepts the result
//   csum        ones-complement checksum of the packet
//   byte_count  qualified bytes: live in ACC, frozen in DONE
module stream_checksum #(
  parameter int DATA_W   = 64,
  parameter int CNT_W    = 16,
  parameter int ZERO_MAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic [15:0]         seed,
  output logic                csum_valid,
  input  logic                csum_ready,
  output logic [15:0]         csum,
  output logic [CNT_W-1:0]    byte_count
);

  localparam int NW    = DATA_W / 16;
  localparam int NB    = DATA_W / 8;
  localparam int PC_W  = $clog2(NB + 1);
  // Wide enough for the running 16-bit value plus NW full words.
  localparam int SUM_W = 16 + $clog2(NW + 2);
  localparam int CW    = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CW-1:0] CNT_MAX = {{(CW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [15:0]        csum_q, csum_d;

  logic [SUM_W-1:0]   sum_s;
  logic [15:0]        word_s;
  logic [15:0]        fold_s;
  logic [PC_W-1:0]    pc_s;
  logic [CW-1:0]      cnt_sum_s;
  logic [CNT_W-1:0]   cnt_sat_s;

  // End-around carry. The sum is at most SUM_W bits, so after two folds it
  // fits in 16 bits; a third pass is kept as margin for every legal DATA_W.
  function automatic logic [15:0] fold16(input logic [SUM_W-1:0] v);
    logic [SUM_W-1:0] s;
    s = v;
    for (int i = 0; i < 3; i++) begin
      s = {{(SUM_W-16){1'b0}}, s[15:0]} + (s >> 16);
    end
    return s[15:0];
  endfunction

  // Complement the folded sum; optionally map a zero checksum to 0xFFFF.
  function automatic logic [15:0] finalize(input logic [15:0] a);
    logic [15:0] c;
    c = ~a;
    if ((ZERO_MAP != 0) && (c == 16'h0000)) begin
      c = 16'hFFFF;
    end else begin
      c = c;
    end
    return c;
  endfunction

  // Masked word sum of the current beat on top of seed (first beat) or acc.
  always_comb begin
    sum_s  = first_q ? {{(SUM_W-16){1'b0}}, seed} : {{(SUM_W-16){1'b0}}, acc_q};
    word_s = 16'h0000;
    for (int k = 0; k < NW; k++) begin
      word_s = s_data[16*k +: 16] & {{8{s_keep[2*k+1]}}, {8{s_keep[2*k]}}};
      sum_s  = sum_s + {{(SUM_W-16){1'b0}}, word_s};
    end
    fold_s = fold16(sum_s);
  end

  // Byte count of the beat and saturating add into the counter.
  always_comb begin
    pc_s = {PC_W{1'b0}};
    for (int j = 0; j < NB; j++) begin
      pc_s = pc_s + {{(PC_W-1){1'b0}}, s_keep[j]};
    end
    cnt_sum_s = {{(CW-CNT_W){1'b0}}, cnt_q} + {{(CW-PC_W){1'b0}}, pc_s};
    if (cnt_sum_s > CNT_MAX) begin
      cnt_sat_s = {CNT_W{1'b1}};
    end else begin
      cnt_sat_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= 16'h0000;
      cnt_q   <= {CNT_W{1'b0}};
      first_q <= 1'b1;
      csum_q  <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state logic: accumulate in ACC, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    csum_d  = csum_q;
    case (state_q)
      ACC: begin
        if (s_valid) begin
          acc_d   = fold_s;
          cnt_d   = cnt_sat_s;
          first_d = 1'b0;
          if (s_last) begin
            state_d = DONE;
            csum_d  = finalize(fold_s);
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      DONE: begin
        if (csum_ready) begin
          state_d = ACC;
          acc_d   = 16'h0000;
          cnt_d   = {CNT_W{1'b0}};
          first_d = 1'b1;
          csum_d  = 16'hFFFF;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = ACC;
        acc_d   = 16'h0000;
        cnt_d   = {CNT_W{1'b0}};
        first_d = 1'b1;
        csum_d  = 16'hFFFF;
      end
    endcase
  end

  assign s_ready    = (state_q == ACC);
  assign csum_valid = (state_q == DONE);
  assign csum       = csum_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_stream_checksum.sv
// tb_stream_checksum
//   Drives two stream_checksum instances with identical stimulus:
//   u_dut1 (CNT_W=16, ZERO_MAP=0) and u_dut2 (CNT_W=4, ZERO_MAP=1, so its
//   counter saturates at 15). Expected values come from a packet-level
//   reference model: the whole packet is summed as a plain integer and folded
//   once at the end.
module tb_stream_checksum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic [15:0] seed;
  logic        csum_ready;

  logic        s_ready1, s_ready2, cv1, cv2;
  logic [15:0] csum1, csum2;
  logic [15:0] bc1;
  logic [3:0]  bc2;

  int total = 0;
  int bad   = 0;

  longint m_sum;
  int     m_cnt;
  bit     m_first;

  always #5 clk = ~clk;

  stream_checksum #(.DATA_W(64), .CNT_W(16), .ZERO_MAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .seed(seed),
    .csum_valid(cv1), .csum_ready(csum_ready), .csum(csum1), .byte_count(bc1)
  );

  stream_checksum #(.DATA_W(64), .CNT_W(4), .ZERO_MAP(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .seed(seed),
    .csum_valid(cv2), .csum_ready(csum_ready), .csum(csum2), .byte_count(bc2)
  );

  task automatic model_clear();
    m_sum   = 0;
    m_cnt   = 0;
    m_first = 1'b1;
  endtask

  // Each qualified byte adds its value at its position within its 16-bit word.
  task automatic model_add(input logic [63:0] d, input logic [7:0] k, input logic [15:0] sd);
    if (m_first) begin
      m_sum   = longint'(sd);
      m_first = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      if (k[j]) begin
        m_sum = m_sum + (longint'(d[8*j +: 8]) << (8 * (j % 2)));
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic logic [15:0] model_csum(input bit zm);
    longint      s;
    logic [15:0] c;
    s = m_sum;
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    c = ~s[15:0];
    if (zm && c == 16'h0000) c = 16'hFFFF;
    return c;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [15:0] sd);
    @(negedge clk);
    s_data = d; s_keep = k; s_last = l; seed = sd; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; seed = 16'($urandom);
    model_add(d, k, sd);
    total++;
    if (!l) begin
      if (bc1 !== 16'(m_cnt) || bc2 !== 4'(sat(m_cnt, 15)) || s_ready1 !== 1'b1 || cv1 !== 1'b0) begin
        bad++;
        $display("FAIL live_count: bc1=%0d bc2=%0d s_ready=%b cv=%b required bc1=%0d bc2=%0d s_ready=1 cv=0",
                 bc1, bc2, s_ready1, cv1, m_cnt, sat(m_cnt, 15));
      end
    end else begin
      if (cv1 !== 1'b1 || cv2 !== 1'b1 || s_ready1 !== 1'b0) begin
        bad++;
        $display("FAIL latency: cv1=%b cv2=%b s_ready=%b required cv=1 s_ready=0", cv1, cv2, s_ready1);
      end
    end
  endtask

  // Check the presented result, hold it for 'hold' cycles, then accept it.
  task automatic finish_pkt(input int hold);
    logic [15:0] e1, e2;
    e1 = model_csum(1'b0);
    e2 = model_csum(1'b1);
    total++;
    if (csum1 !== e1 || bc1 !== 16'(sat(m_cnt, 65535))) begin
      bad++;
      $display("FAIL result1: csum=%h bc=%0d required csum=%h bc=%0d", csum1, bc1, e1, m_cnt);
    end
    total++;
    if (csum2 !== e2 || bc2 !== 4'(sat(m_cnt, 15))) begin
      bad++;
      $display("FAIL result2: csum=%h bc=%0d required csum=%h bc=%0d", csum2, bc2, e2, sat(m_cnt, 15));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (cv1 !== 1'b1 || s_ready1 !== 1'b0 || csum1 !== e1 || bc1 !== 16'(m_cnt)) begin
        bad++;
        $display("FAIL hold: cv=%b s_ready=%b csum=%h bc=%0d required cv=1 s_ready=0 csum=%h bc=%0d",
                 cv1, s_ready1, csum1, bc1, e1, m_cnt);
      end
    end
    @(negedge clk);
    csum_ready = 1'b1;
    @(posedge clk);
    #1;
    csum_ready = 1'b0;
    total++;
    if (cv1 !== 1'b0 || s_ready1 !== 1'b1 || bc1 !== 16'd0 || csum1 !== 16'hFFFF) begin
      bad++;
      $display("FAIL release: cv=%b s_ready=%b bc=%0d csum=%h required cv=0 s_ready=1 bc=0 csum=ffff",
               cv1, s_ready1, bc1, csum1);
    end
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    seed = 16'h0000; csum_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cv1 !== 1'b0 || s_ready1 !== 1'b1 || csum1 !== 16'hFFFF || bc1 !== 16'd0 || cv2 !== 1'b0 || bc2 !== 4'd0) begin
      bad++;
      $display("FAIL reset: cv=%b s_ready=%b csum=%h bc=%0d required cv=0 s_ready=1 csum=ffff bc=0",
               cv1, s_ready1, csum1, bc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    // Four words 1..4 with seed 0.
    beat(64'h0004_0003_0002_0001, 8'hFF, 1'b1, 16'h0000);
    total++;
    if (csum1 !== 16'hFFF5 || bc1 !== 16'd8) begin
      bad++;
      $display("FAIL vec_words: csum=%h bc=%0d required csum=fff5 bc=8", csum1, bc1);
    end
    finish_pkt(0);
    // All ones over two beats: zero checksum, mapped on the ZERO_MAP instance.
    beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 16'h0000);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 16'h1234);
    total++;
    if (csum1 !== 16'h0000 || csum2 !== 16'hFFFF || bc1 !== 16'd16 || bc2 !== 4'd15) begin
      bad++;
      $display("FAIL vec_ones: csum1=%h csum2=%h bc1=%0d bc2=%0d required 0000 ffff 16 15", csum1, csum2, bc1, bc2);
    end
    finish_pkt(1);
    // End-around carry out of the seed.
    beat(64'h5555_6666_7777_0010, 8'h03, 1'b1, 16'hFFF0);
    total++;
    if (csum1 !== 16'hFFFE || bc1 !== 16'd2) begin
      bad++;
      $display("FAIL vec_carry: csum=%h bc=%0d required csum=fffe bc=2", csum1, bc1);
    end
    finish_pkt(0);
    // Upper bytes masked off.
    beat(64'hAAAA_BBBB_0002_0001, 8'h0F, 1'b1, 16'h0000);
    total++;
    if (csum1 !== 16'hFFFC || bc1 !== 16'd4) begin
      bad++;
      $display("FAIL vec_keep: csum=%h bc=%0d required csum=fffc bc=4", csum1, bc1);
    end
    finish_pkt(0);
    // Empty last beat still produces a result.
    beat(64'h0000_0000_0000_0005, 8'h01, 1'b0, 16'h0100);
    beat(64'hDEAD_BEEF_CAFE_F00D, 8'h00, 1'b1, 16'h7777);
    total++;
    if (csum1 !== 16'hFEFA || bc1 !== 16'd1) begin
      bad++;
      $display("FAIL vec_empty_last: csum=%h bc=%0d required csum=fefa bc=1", csum1, bc1);
    end
    finish_pkt(0);
  endtask

  task automatic test_backpressure();
    logic [15:0] e1;
    beat(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 16'h0042);
    e1 = model_csum(1'b0);
    @(negedge clk);
    s_data = 64'h0000_0000_0009_0008; s_keep = 8'h0F; s_last = 1'b1;
    seed = 16'h0100; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (cv1 !== 1'b1 || s_ready1 !== 1'b0 || csum1 !== e1 || bc1 !== 16'd8) begin
        bad++;
        $display("FAIL bp_hold: cv=%b s_ready=%b csum=%h bc=%0d required cv=1 s_ready=0 csum=%h bc=8",
                 cv1, s_ready1, csum1, bc1, e1);
      end
      @(negedge clk);
    end
    csum_ready = 1'b1;
    @(posedge clk);
    #1;
    csum_ready = 1'b0;
    model_clear();
    total++;
    if (cv1 !== 1'b0 || bc1 !== 16'd0 || s_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL bp_not_consumed: cv=%b bc=%0d s_ready=%b required cv=0 bc=0 s_ready=1", cv1, bc1, s_ready1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    model_add(64'h0000_0000_0009_0008, 8'h0F, 16'h0100);
    total++;
    if (cv1 !== 1'b1 || csum1 !== 16'hFEEE) begin
      bad++;
      $display("FAIL bp_consumed: cv=%b csum=%h required cv=1 csum=feee", cv1, csum1);
    end
    finish_pkt(0);
  endtask

  task automatic test_reset_mid();
    beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 16'h0F0F);
    beat(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (bc1 !== 16'd0 || s_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_async: bc=%0d s_ready=%b required bc=0 s_ready=1", bc1, s_ready1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    beat(64'h0000_0000_0000_0003, 8'h03, 1'b1, 16'h0010);
    total++;
    if (csum1 !== 16'hFFEC || bc1 !== 16'd2) begin
      bad++;
      $display("FAIL reset_fresh: csum=%h bc=%0d required csum=ffec bc=2", csum1, bc1);
    end
    // Reset while a result is pending discards it.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (cv1 !== 1'b0 || csum1 !== 16'hFFFF || bc1 !== 16'd0) begin
      bad++;
      $display("FAIL reset_done: cv=%b csum=%h bc=%0d required cv=0 csum=ffff bc=0", cv1, csum1, bc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) begin
        beat({$urandom, $urandom}, 8'($urandom_range(0, 255)), (b == n - 1), 16'($urandom));
      end
      finish_pkt($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_checksum.md
STREAM_CHECKSUM -- requirements
Module: stream_checksum

Interface
REQ-001 SHALL have parameter DATA_W, default 64: input word width in bits; it must be a multiple of 16 in the range 16..512.
REQ-002 SHALL have parameter CNT_W, default 16: width of the byte counter.
REQ-003 SHALL have parameter ZERO_MAP, default 0: when 1, a computed checksum of 0x0000 is emitted as 0xFFFF (UDP rule).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: an input beat is present.
REQ-007 SHALL have port s_ready, output, 1 bit: the block can accept an input beat.
REQ-008 SHALL have port s_data, input, DATA_W bits: 16-bit word k = s_data[16k+15:16k].
REQ-009 SHALL have port s_keep, input, DATA_W/8 bits: bit j qualifies byte s_data[8j+7:8j].
REQ-010 SHALL have port s_last, input, 1 bit: the beat is the final beat of a packet.
REQ-011 SHALL have port seed, input, 16 bits: initial partial sum, e.g. a pseudo-header sum.
REQ-012 SHALL have port csum_valid, output, 1 bit: a result is presented.
REQ-013 SHALL have port csum_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port csum, output, 16 bits: ones-complement checksum of the packet.
REQ-015 SHALL have port byte_count, output, CNT_W bits: number of qualified bytes in the packet.

Function
REQ-016 SHALL accept an input beat only when s_valid and s_ready are both 1 in the same cycle.
REQ-017 SHALL implement a state machine with two states, ACC and DONE. ACC drives s_ready=1 and csum_valid=0. DONE drives s_ready=0 and csum_valid=1.
REQ-018 SHALL sample seed only on the first accepted beat of each packet, i.e. the first beat after reset or after a result handshake; seed is ignored on every other cycle.
REQ-019 SHALL treat each byte whose s_keep bit is 0 as 0x00 before summing.
REQ-020 SHALL compute, for each accepted beat: acc_next = fold(acc + all DATA_W/16 masked words), where acc is taken as seed on the first beat.
REQ-021 SHALL have fold() add the bits above bit 15 back into the low 16 bits (end-around carry), repeating until the value fits in 16 bits, all within the same cycle; no carry may be lost for any DATA_W.
REQ-022 SHALL add popcount(s_keep) to the byte counter on each accepted beat, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL, on an accepted beat with s_last=1, move from ACC to DONE on that clock edge, so csum_valid is 1 in the next cycle (1-cycle latency).
REQ-024 SHALL drive csum = ~acc in DONE; if ZERO_MAP=1 and ~acc == 0x0000, csum SHALL be 0xFFFF.
REQ-025 SHALL hold csum and byte_count stable while csum_valid=1 and csum_ready=0.
REQ-026 SHALL, on the cycle where csum_valid and csum_ready are both 1, return to ACC and clear acc and the byte counter, so the next beat is treated as a first beat.
REQ-027 SHALL treat a last beat with s_keep all zero as valid: it contributes 0 to the sum and the result is still produced.
REQ-028 SHALL let a single-beat packet (first beat with s_last=1) produce fold(seed + words).
REQ-029 SHALL drive byte_count as the live counter in ACC and the frozen final count in DONE.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: state=ACC, acc=0, counter=0, s_ready=1 once released, csum_valid=0, csum=0xFFFF, byte_count=0.
REQ-031 SHALL, on reset asserted mid-packet or while in DONE, discard the partial or pending result; the first beat after release is a first beat.

Verification
REQ-032 SHALL be covered by: DATA_W=64, seed=0, one beat 0x0004_0003_0002_0001, keep=0xFF, last=1 -> csum=0xFFF5, byte_count=8, one cycle after the beat.
REQ-033 SHALL be covered by: two beats of all-ones, keep=0xFF, seed=0 -> sum folds to 0xFFFF -> csum=0x0000; with ZERO_MAP=1 -> csum=0xFFFF; byte_count=16.
REQ-034 SHALL be covered by: seed=0xFFF0, data=0x0010 in word 0, keep=0x03 -> fold 0x10000 to 0x0001 -> csum=0xFFFE, byte_count=2.
REQ-035 SHALL be covered by: data 0xAAAA_BBBB_0002_0001, keep=0x0F -> csum=0xFFFC, byte_count=4.
REQ-036 SHALL be covered by: csum_ready held at 0 for 5 cycles after a result -> s_ready=0, csum stable throughout; a beat offered then is not consumed until the cycle after the handshake.
REQ-037 SHALL be covered by: rst_n pulsed low after 2 beats of a 4-beat packet, then a fresh 1-beat packet -> the result reflects only the fresh packet and its seed.
